cp0_exc_ctrl: RTL

//   Coprocessor-0 exception/interrupt controller. Sits at the M stage.
//   - Drives `req` to the fetch-stage PC register, which redirects fetch to the handler entry.
//   - Holds SR, Cause and EPC; serves mtc0/mfc0; clears EXL on eret.
//   - Supplies EPCOut for the eret return target.

---
 rtl/cp0_exc_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: holds SR, Cause and EPC,
// raises a same-cycle redirect request, and serves mtc0/mfc0/eret.
module cp0_exc_ctrl #(
  parameter int          HWINT_W    = 6,
  parameter logic [4:0]  SR_ADDR    = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR = 5'd13,
  parameter logic [4:0]  EPC_ADDR   = 5'd14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        PC,
  input  logic [4:0]         ExcCodeIn,
  input  logic               BDIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  input  logic               en,
  input  logic [4:0]         CP0Addr,
  input  logic [31:0]        CP0In,
  output logic [31:0]        CP0Out,
  output logic [31:0]        EPCOut,
  output logic               req
);

  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_aligned;
  logic [31:0] epc_exc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign req     = ~reset & (int_req | exc_req);

  // A faulting delay-slot instruction restarts at its branch.
  assign pc_aligned = PC & ~32'd3;
  assign epc_exc    = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = epc_exc;
    end else if (EXLClr) begin
      exl_d = 1'b0;
    end else if (en) begin
      if (CP0Addr == SR_ADDR) begin
        im_d  = CP0In[10 +: HWINT_W];
        exl_d = CP0In[1];
        ie_d  = CP0In[0];
      end else if (CP0Addr == EPC_ADDR) begin
        epc_d = CP0In & ~32'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_rd                   = 32'd0;
    sr_rd[10 +: HWINT_W]    = im_q;
    sr_rd[1]                = exl_q;
    sr_rd[0]                = ie_q;
    cause_rd                = 32'd0;
    cause_rd[31]            = bd_q;
    cause_rd[10 +: HWINT_W] = ip_q;
    cause_rd[6:2]           = exc_code_q;
  end

  always_comb begin
    CP0Out = 32'd0;
    if (CP0Addr == SR_ADDR)         CP0Out = sr_rd;
    else if (CP0Addr == CAUSE_ADDR) CP0Out = cause_rd;
    else if (CP0Addr == EPC_ADDR)   CP0Out = epc_q;
  end

  assign EPCOut = epc_q;

endmodule
